pipelined_wallace_mul: RTL and testbench
========================================

PIPELINED_WALLACE_MUL -- requirements
Module: pipelined_wallace_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 4..32.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: operand pair a/b present.
REQ-005 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-006 SHALL have port a, input, WIDTH: multiplicand.
REQ-007 SHALL have port b, input, WIDTH: multiplier.
REQ-008 SHALL have port signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-009 SHALL have port out_valid, output, 1: prod holds a valid result.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts prod this cycle.
REQ-011 SHALL have port prod, output, 2*WIDTH: full product, no truncation.

Function
REQ-012 SHALL form WIDTH partial-product rows by bitwise AND of a with each bit of b.
REQ-013 SHALL reduce the rows with full/half-adder Wallace tree layers to two rows, then add those two rows with a carry-propagate adder.
REQ-014 SHALL use exactly 3 register stages: S1 = partial products plus first reduction layers; S2 = remaining reduction to two rows; S3 = final sum into prod.
REQ-015 SHALL define advance = !out_valid || out_ready; all stages shift one position only when advance = 1.
REQ-016 SHALL drive in_ready = advance && !rst.
REQ-017 SHALL accept an operand pair on a cycle where in_valid && in_ready; otherwise a bubble (valid bit 0) enters S1 when advance = 1.
REQ-018 SHALL present a result on out_valid exactly 3 cycles after acceptance when out_ready stays high; latency grows by one cycle per stall cycle.
REQ-019 SHALL sustain one result per cycle while in_valid and out_ready are held high.
REQ-020 SHALL hold prod and out_valid stable while out_valid && !out_ready, and SHALL not drop or duplicate any in-flight operation.
REQ-021 SHALL accept new operands in the same cycle that the S3 result is consumed (out_valid && out_ready).
REQ-022 SHALL keep a per-stage signed_mode tag so that mixed-mode back-to-back operations each use their own mode.
REQ-023 SHALL produce prod = a*b mod 2^(2*WIDTH) in signed mode, sign-correct across the full range, including -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-024 SHALL leave prod content undefined when out_valid = 0; verification SHALL check prod only on valid cycles.

Reset
REQ-025 SHALL clear all stage valid bits and out_valid to 0 on any clock edge with rst = 1, including mid-operation; in-flight operations are discarded.
REQ-026 SHALL reset prod and the data registers to 0.
REQ-027 SHALL hold in_ready = 0 while rst = 1, and SHALL restore it to 1 in the first cycle after rst is released.

Configuration
REQ-028 SHALL compile in signed support under macro WALLACE_MUL_SIGNED_EN, using Baugh-Wooley sign-bit complementing of partial products and correction constants.
REQ-029 SHALL keep the signed_mode port when WALLACE_MUL_SIGNED_EN is undefined, but SHALL ignore it, treat all operands as unsigned, and build no signed correction logic.

Verification
REQ-030 SHALL cover: WIDTH=8, unsigned, a=255, b=255, out_ready=1 -> prod=0xFE01 with out_valid exactly 3 cycles after accept.
REQ-031 SHALL cover: WIDTH=8, SIGNED_EN defined, signed_mode=1, a=0x80, b=0x80 -> prod=0x4000; then a=0xFF, b=0x01 -> prod=0xFFFF on the next cycle.
REQ-032 SHALL cover: 4 back-to-back accepts (3*5, 7*9, 0*200, 1*1) with out_ready held 0 for 5 cycles after the first out_valid -> in_ready low during the stall; outputs then 15, 63, 0, 1 in order with no loss.
REQ-033 SHALL cover: rst pulsed for 1 cycle while 2 operations are in flight -> out_valid=0 the next cycle; no stale result ever appears; the next accept yields its correct product 3 cycles later.
REQ-034 SHALL cover: WIDTH=16 with 10,000 random operands, random signed_mode and random out_ready -> each result matches the reference model in order, with throughput 1/cycle whenever out_ready=1.

Source files
------------

// File: rtl/pipelined_wallace_mul.sv
// pipelined_wallace_mul: 3-stage Wallace-tree multiplier with valid/ready handshake, macro WALLACE_MUL_SIGNED_EN adds Baugh-Wooley signed mode
module pipelined_wallace_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);
  localparam int P = 2 * WIDTH;
`ifdef WALLACE_MUL_SIGNED_EN
  localparam int NR = WIDTH + 1;
`else
  localparam int NR = WIDTH;
`endif
  function automatic int nlayers(int n);
    int k = 0;
    for (int m = n; m > 2; m = m - m / 3) k++;
    return k;
  endfunction
  function automatic int nrows(int n, int k);
    int m = n;
    for (int l = 0; l < k; l++) m = m - m / 3;
    return m;
  endfunction
  localparam int L = nlayers(NR);
  localparam int L1 = (L + 1) / 2;
  localparam int N1 = nrows(NR, L1);
  typedef logic [NR-1:0][P-1:0] rows_t;
  typedef logic [N1-1:0][P-1:0] r1_t;
  typedef logic [1:0][P-1:0] r2_t;
  function automatic rows_t csa(rows_t x, int n, int k);
    rows_t y;
    for (int l = 0; l < k; l++) begin
      y = '0;
      for (int g = 0; g < n / 3; g++) begin
        y[2*g]   = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
        y[2*g+1] = ((x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) | (x[3*g+1] & x[3*g+2])) << 1;
      end
      for (int m = 0; m < n % 3; m++) y[2*(n/3)+m] = x[3*(n/3)+m];
      x = y;
      n = n - n / 3;
    end
    return x;
  endfunction
  function automatic r1_t stage1(rows_t x);
    rows_t y;
    y = csa(x, NR, L1);
    return y[N1-1:0];
  endfunction
  function automatic r2_t stage2(r1_t x);
    rows_t y;
    y = '0;
    y[N1-1:0] = x;
    y = csa(y, N1, L - L1);
    return y[1:0];
  endfunction
  rows_t pp;
  r1_t   s1;
  r2_t   s2;
  logic  v1, v2, adv;
`ifdef WALLACE_MUL_SIGNED_EN
  // Baugh-Wooley: complement every bit that pairs exactly one sign bit, then add 2^W + 2^(2W-1)
  localparam logic [WIDTH-1:0] LO = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] HI = {1'b1, {(WIDTH-1){1'b0}}};
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++)
      pp[i] = P'((a & {WIDTH{b[i]}}) ^ (signed_mode ? (i == WIDTH - 1 ? LO : HI) : '0)) << i;
    pp[WIDTH] = signed_mode ? ((P'(1) << WIDTH) | (P'(1) << (P - 1))) : '0;
  end
`else
  logic unused_sm;
  assign unused_sm = signed_mode;
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) pp[i] = P'(a & {WIDTH{b[i]}}) << i;
  end
`endif
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  // the mode only shapes the partial products, so it is fully captured in s1 per operation
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s1        <= '0;
      s2        <= '0;
      prod      <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      s1        <= stage1(pp);
      v2        <= v1;
      s2        <= stage2(s1);
      out_valid <= v2;
      prod      <= s2[0] + s2[1];
    end
  end
endmodule

// File: tb/tb_pipelined_wallace_mul.sv
// tb_pipelined_wallace_mul: table vectors on WIDTH=8, stall/reset sequences, random WIDTH=16 scoreboard run
module tb_pipelined_wallace_mul;
`ifdef WALLACE_MUL_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] e;
  } vec_t;
  typedef struct {
    logic [31:0] p;
    int          acc;
    int          ns;
  } ent_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        sm = 1'b0;
  logic        iv8 = 1'b0, iv16 = 1'b0, ord8 = 1'b1, ord16 = 1'b1;
  logic        rdy8, rdy16, ov8, ov16;
  logic [15:0] p8;
  logic [31:0] p16;
  ent_t        q[$];
  vec_t        tv[12];
  int          cyc = 0, nstall = 0, total = 0, bad = 0, nacc = 0, tstart = 0;
  bit          seen = 1'b0, sel = 1'b0;
  pipelined_wallace_mul #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a[7:0]), .b(b[7:0]),
    .signed_mode(sm), .out_valid(ov8), .out_ready(ord8), .prod(p8)
  );
  pipelined_wallace_mul #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .a(a), .b(b),
    .signed_mode(sm), .out_valid(ov16), .out_ready(ord16), .prod(p16)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask
  function automatic logic [31:0] mdl(logic [15:0] x, logic [15:0] y, logic s);
    longint r;
    r = (s && SEN) ? longint'($signed(x)) * longint'($signed(y))
                   : longint'({16'h0, x}) * longint'({16'h0, y});
    return r[31:0];
  endfunction
  // one clock cycle on the selected DUT: drive, sample at negedge, score, advance
  task automatic tick(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ism, input logic ord, input logic [31:0] e);
    logic        ov, rdy;
    logic [31:0] p;
    a = ia;
    b = ib;
    sm = ism;
    iv8 = sel ? 1'b0 : iv;
    iv16 = sel ? iv : 1'b0;
    ord8 = sel ? 1'b1 : ord;
    ord16 = sel ? ord : 1'b1;
    @(negedge clk);
    ov = sel ? ov16 : ov8;
    rdy = sel ? rdy16 : rdy8;
    p = sel ? p16 : {16'h0, p8};
    chk("in_ready", 32'(rdy), 32'((!ov || ord) && !rst));
    if (sel && iv && cyc >= tstart + 3) chk("tput", 32'(ov), 1);
    if (ov) begin
      chk("stray_valid", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        chk("prod", p, q[0].p);
        if (!seen) begin
          chk("latency", 32'(cyc - q[0].acc), 32'(3 + nstall - q[0].ns));
          seen = 1'b1;
        end
        if (ord) begin
          void'(q.pop_front());
          seen = 1'b0;
        end else nstall++;
      end
    end
    if (iv && rdy) begin
      q.push_back('{e, cyc, nstall});
      nacc++;
    end
    if (rst) begin
      q.delete();
      seen = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, '0);
    chk("drained", 32'(q.size()), 0);
  endtask
  initial begin
    tv[0]  = '{16'hFF, 16'hFF, 1'b0, 32'hFE01};
    tv[1]  = '{16'h80, 16'h80, 1'b1, 32'h4000};
    tv[2]  = '{16'hFF, 16'h01, 1'b1, SEN ? 32'hFFFF : 32'h00FF};
    tv[3]  = '{16'h7F, 16'h80, 1'b1, SEN ? 32'hC080 : 32'h3F80};
    tv[4]  = '{16'hFF, 16'hFF, 1'b1, SEN ? 32'h0001 : 32'hFE01};
    tv[5]  = '{16'h0A, 16'hF6, 1'b1, SEN ? 32'hFF9C : 32'h099C};
    tv[6]  = '{16'h80, 16'h01, 1'b1, SEN ? 32'hFF80 : 32'h0080};
    tv[7]  = '{16'h7F, 16'h7F, 1'b1, 32'h3F01};
    tv[8]  = '{16'd12, 16'd13, 1'b0, 32'h009C};
    tv[9]  = '{16'h80, 16'hFF, 1'b0, 32'h7F80};
    tv[10] = '{16'hFF, 16'h80, 1'b1, SEN ? 32'h0080 : 32'h7F80};
    tv[11] = '{16'h00, 16'hFF, 1'b1, 32'h0000};
    rst = 1'b1;
    tick(1'b1, 16'd3, 16'd3, 1'b0, 1'b1, 32'd9);
    tick(1'b1, 16'd3, 16'd3, 1'b0, 1'b1, 32'd9);
    chk("rst_out_valid", 32'(ov8), 0);
    chk("rst_prod", {16'h0, p8}, 0);
    chk("rst_in_ready", 32'(rdy8), 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick(1'b1, tv[i].a, tv[i].b, tv[i].sm, 1'b1, tv[i].e);
    drain();
    tick(1'b1, 16'd3, 16'd5, 1'b0, 1'b1, 32'd15);
    tick(1'b1, 16'd7, 16'd9, 1'b0, 1'b1, 32'd63);
    tick(1'b1, 16'd0, 16'd200, 1'b0, 1'b1, 32'd0);
    tick(1'b1, 16'd1, 16'd1, 1'b0, 1'b1, 32'd1);
    chk("stall_depth", 32'(q.size()), 3);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'd2, 16'd2, 1'b0, 1'b0, 32'd4);
      chk("stall_held", 32'(ov8), 1);
    end
    chk("stall_no_accept", 32'(q.size()), 3);
    drain();
    tick(1'b1, 16'd6, 16'd7, 1'b0, 1'b1, 32'd42);
    tick(1'b1, 16'd9, 16'd9, 1'b0, 1'b1, 32'd81);
    rst = 1'b1;
    tick(1'b0, '0, '0, 1'b0, 1'b1, '0);
    rst = 1'b0;
    chk("flush_out_valid", 32'(ov8), 0);
    tick(1'b1, 16'd11, 16'd12, 1'b0, 1'b1, 32'd132);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, '0);
    chk("flush_done", 32'(q.size()), 0);
    sel = 1'b1;
    nacc = 0;
    tstart = cyc;
    for (int k = 0; k < 30000 && nacc < 10000; k++) begin
      logic [15:0] ra, rb;
      logic        rs, ro;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      ro = $urandom_range(3) != 0;
      tick(1'b1, ra, rb, rs, ro, mdl(ra, rb, rs));
    end
    chk("rand_count", 32'(nacc), 10000);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
